splitter: RTL and testbench

Combinational-decode, registered-output opcode field extractor in the 2D GPU draw path. It takes one 74-bit shape opcode and a 4-bit output selector from the drawing controller. Each cycle it presents the pair of 19-bit pixel locations that the selected primitive phase needs (line endpoints, a triangle edge, or circle center/radius), together with the shape colour. Downstream rasterisers consume `locations` and `color` directly.

---
 rtl/splitter.sv | 65 ++++++
 tb/tb_splitter.sv | 116 +++++++++++
 2 files changed

// File: rtl/splitter.sv
// Registered opcode field extractor: slices a 74-bit shape opcode and presents the
// location pair for the selected primitive phase, plus colour and fill, one cycle later.
module splitter (
  input  logic        clk,
  input  logic        rst,
  input  logic [73:0] opdata,
  input  logic [3:0]  output_sel,
  output logic [37:0] locations,
  output logic [15:0] color,
  output logic        fill,
  output logic        sel_err
);

  localparam logic [3:0] SEL_LL1 = 4'b0000;
  localparam logic [3:0] SEL_TL1 = 4'b0001;
  localparam logic [3:0] SEL_TL2 = 4'b0010;
  localparam logic [3:0] SEL_TL3 = 4'b0011;
  localparam logic [3:0] SEL_CA1 = 4'b0100;

  logic [18:0] loc1, loc2, loc3;

  logic [37:0] locations_d, locations_q;
  logic [15:0] color_d, color_q;
  logic        fill_d, fill_q;
  logic        sel_err_d, sel_err_q;

  assign loc1 = opdata[57:39];
  assign loc2 = opdata[38:20];
  assign loc3 = opdata[19:1];

  always_comb begin
    // NOTE: every output of this block gets a default before the case so no latch is inferred.
    locations_d = 38'h0;
    sel_err_d   = 1'b0;
    color_d     = opdata[73:58];
    fill_d      = opdata[0];
    case (output_sel)
      SEL_LL1, SEL_TL1, SEL_CA1: locations_d = {loc1, loc2};
      SEL_TL2:                   locations_d = {loc1, loc3};
      SEL_TL3:                   locations_d = {loc2, loc3};
      default:                   sel_err_d   = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (rst) begin
      locations_q <= 38'h0;
      color_q     <= 16'h0;
      fill_q      <= 1'b0;
      sel_err_q   <= 1'b0;
    end else begin
      locations_q <= locations_d;
      color_q     <= color_d;
      fill_q      <= fill_d;
      sel_err_q   <= sel_err_d;
    end
  end

  assign locations = locations_q;
  assign color     = color_q;
  assign fill      = fill_q;
  assign sel_err   = sel_err_q;

endmodule

// File: tb/tb_splitter.sv
// Directed bench for splitter: hand-computed vectors for each phase, unused codes,
// reset priority and a mid-triangle reset, then a field-walk regression loop.
module tb_splitter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [73:0] opdata = '0;
  logic [3:0]  output_sel = '0;
  logic [37:0] locations;
  logic [15:0] color;
  logic        fill;
  logic        sel_err;

  int n_checks = 0;
  int n_errors = 0;

  splitter dut (
    .clk        (clk),
    .rst        (rst),
    .opdata     (opdata),
    .output_sel (output_sel),
    .locations  (locations),
    .color      (color),
    .fill       (fill),
    .sel_err    (sel_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Apply inputs mid-cycle, let one rising edge capture them, sample just after.
  task automatic drive(input logic r, input logic [3:0] s, input logic [73:0] d);
    @(negedge clk);
    rst        = r;
    output_sel = s;
    opdata     = d;
    @(posedge clk);
    #1;
  endtask

  task automatic check_all(input string tag, input logic [37:0] e_loc, input logic [15:0] e_col,
                           input logic e_fill, input logic e_err);
    check({tag, ".loc"},  64'(locations), 64'(e_loc));
    check({tag, ".col"},  64'(color),     64'(e_col));
    check({tag, ".fill"}, 64'(fill),      64'(e_fill));
    check({tag, ".err"},  64'(sel_err),   64'(e_err));
  endtask

  logic [73:0] op_a;
  logic [73:0] op_c;

  initial begin
    op_a = {16'hF81F, 19'h12345, 19'h0ABCD, 19'h7FFFF, 1'b1};
    op_c = {16'h1234, 19'h00100, 19'h00020, 19'h00003, 1'b0};

    drive(1'b1, 4'b0000, {74{1'b1}});
    check_all("reset", 38'h0, 16'h0, 1'b0, 1'b0);

    drive(1'b0, 4'b0000, op_a);
    check_all("line", {19'h12345, 19'h0ABCD}, 16'hF81F, 1'b1, 1'b0);

    drive(1'b0, 4'b0001, op_a);
    check_all("tl1", {19'h12345, 19'h0ABCD}, 16'hF81F, 1'b1, 1'b0);
    drive(1'b0, 4'b0010, op_a);
    check_all("tl2", {19'h12345, 19'h7FFFF}, 16'hF81F, 1'b1, 1'b0);
    drive(1'b0, 4'b0011, op_a);
    check_all("tl3", {19'h0ABCD, 19'h7FFFF}, 16'hF81F, 1'b1, 1'b0);

    drive(1'b0, 4'b0100, op_c);
    check_all("circle", {19'h00100, 19'h00020}, 16'h1234, 1'b0, 1'b0);

    drive(1'b0, 4'b1010, op_a);
    check_all("unused_1010", 38'h0, 16'hF81F, 1'b1, 1'b1);
    drive(1'b0, 4'b0000, op_a);
    check_all("err_clear", {19'h12345, 19'h0ABCD}, 16'hF81F, 1'b1, 1'b0);

    drive(1'b0, 4'b0101, op_c);
    check_all("unused_0101", 38'h0, 16'h1234, 1'b0, 1'b1);
    drive(1'b0, 4'b1111, op_a);
    check_all("unused_1111", 38'h0, 16'hF81F, 1'b1, 1'b1);

    // Reset wins over an unused selector that would otherwise raise sel_err.
    drive(1'b1, 4'b1111, op_a);
    check_all("rst_prio", 38'h0, 16'h0, 1'b0, 1'b0);

    // Reset between TL2 and TL3, then TL3 loads on the very next edge.
    drive(1'b0, 4'b0001, op_a);
    drive(1'b0, 4'b0010, op_a);
    check_all("mid_tl2", {19'h12345, 19'h7FFFF}, 16'hF81F, 1'b1, 1'b0);
    drive(1'b1, 4'b0011, op_a);
    check_all("mid_rst", 38'h0, 16'h0, 1'b0, 1'b0);
    drive(1'b0, 4'b0011, op_a);
    check_all("mid_tl3", {19'h0ABCD, 19'h7FFFF}, 16'hF81F, 1'b1, 1'b0);

    // Walk a single set bit through each field so swapped or shifted slices show up.
    for (int i = 0; i < 19; i++) begin
      logic [18:0] b;
      b = 19'h1 << i;
      drive(1'b0, 4'b0010, {16'h0, b, 19'h0, ~b, 1'b0});
      check_all("walk_tl2", {b, ~b}, 16'h0, 1'b0, 1'b0);
      drive(1'b0, 4'b0011, {16'h8000 >> (i % 16), 19'h0, b, 19'h0, 1'b1});
      check_all("walk_tl3", {b, 19'h0}, 16'h8000 >> (i % 16), 1'b1, 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
